// File: rtl/wtile_load_sched.sv
// Job sequencer for the W-tile column loader: walks a contiguous k range one column at a
// time, hands each column to the MAC consumer, and slots CPU weight writes between columns.
module wtile_load_sched #(
    parameter int KMAX          = 1024,
    parameter int K_W           = (KMAX <= 1) ? 1 : $clog2(KMAX),
    parameter int CPU_BURST_MAX = 8,
    parameter int TIMEOUT       = 256
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           job_start,
    input  logic [K_W-1:0] job_k_base,
    input  logic [K_W:0]   job_k_len,
    input  logic           job_abort,
    output logic           job_ready,
    output logic           job_done,
    output logic           job_err,
    output logic [K_W:0]   cols_done,
    output logic           start_k,
    output logic [K_W-1:0] k_idx,
    input  logic           col_valid,
    output logic           col_accept,
    output logic           cons_valid,
    input  logic           cons_ready,
    input  logic           cpu_req,
    output logic           cpu_gnt
);

    localparam int BW  = $clog2(CPU_BURST_MAX + 1);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [K_W+1:0] KMAX_W     = (K_W+2)'(KMAX);
    localparam logic [BW-1:0]  BURST_LAST = BW'(CPU_BURST_MAX);
    localparam logic [WDW-1:0] TO_LAST    = WDW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CPU, S_LOAD} state_t;

    state_t         state_reg;
    logic [K_W-1:0] cur_k_reg;
    logic [K_W:0]   remaining_reg;
    logic           skip_cpu_reg;
    logic           abort_pend_reg;
    logic [BW-1:0]  burst_reg;
    logic [WDW-1:0] wd_reg;
    logic           job_done_reg;
    logic           job_err_reg;
    logic           start_k_reg;
    logic [K_W:0]   cols_done_reg;
    logic [K_W-1:0] k_idx_reg;

    logic [K_W+1:0] job_end;
    logic [BW-1:0]  burst_inc;
    logic [WDW-1:0] wd_inc;
    logic           in_load;

    assign job_end   = {2'b00, job_k_base} + {1'b0, job_k_len};
    assign burst_inc = burst_reg + BW'(1);
    assign wd_inc    = wd_reg + WDW'(1);
    assign in_load   = (state_reg == S_LOAD);

    // Handshake outputs are combinational so a column is taken in the cycle it is offered;
    // once an abort is pending the column is drained without being shown to the consumer.
    assign cons_valid = in_load & col_valid & ~abort_pend_reg;
    assign col_accept = in_load & col_valid & (cons_ready | abort_pend_reg);
    assign cpu_gnt    = cpu_req & ~rst & ((state_reg == S_IDLE) | (state_reg == S_CPU));
    assign job_ready  = ~rst & (state_reg == S_IDLE);

    assign job_done  = job_done_reg;
    assign job_err   = job_err_reg;
    assign start_k   = start_k_reg;
    assign cols_done = cols_done_reg;
    assign k_idx     = k_idx_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cur_k_reg      <= '0;
            remaining_reg  <= '0;
            skip_cpu_reg   <= 1'b0;
            abort_pend_reg <= 1'b0;
            burst_reg      <= '0;
            wd_reg         <= '0;
            job_done_reg   <= 1'b0;
            job_err_reg    <= 1'b0;
            start_k_reg    <= 1'b0;
            cols_done_reg  <= '0;
            k_idx_reg      <= '0;
        end else begin
            job_done_reg <= 1'b0;
            job_err_reg  <= 1'b0;
            start_k_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (job_start) begin
                        if (job_end > KMAX_W) begin
                            job_err_reg <= 1'b1;
                        end else if (job_k_len == '0) begin
                            job_done_reg  <= 1'b1;
                            cols_done_reg <= '0;
                        end else begin
                            cur_k_reg     <= job_k_base;
                            remaining_reg <= job_k_len;
                            cols_done_reg <= '0;
                            skip_cpu_reg  <= 1'b0;
                            state_reg     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (job_abort) begin
                        state_reg <= S_IDLE;
                    end else if (cpu_req && !skip_cpu_reg) begin
                        burst_reg <= '0;
                        state_reg <= S_CPU;
                    end else begin
                        start_k_reg    <= 1'b1;
                        k_idx_reg      <= cur_k_reg;
                        skip_cpu_reg   <= 1'b0;
                        wd_reg         <= '0;
                        abort_pend_reg <= 1'b0;
                        state_reg      <= S_LOAD;
                    end
                end
                S_CPU: begin
                    // skip_cpu forces one column before the CPU may be granted again
                    if (job_abort) begin
                        state_reg <= S_IDLE;
                    end else if (!cpu_req) begin
                        skip_cpu_reg <= 1'b1;
                        state_reg    <= S_ISSUE;
                    end else begin
                        burst_reg <= burst_inc;
                        if (burst_inc == BURST_LAST) begin
                            skip_cpu_reg <= 1'b1;
                            state_reg    <= S_ISSUE;
                        end
                    end
                end
                S_LOAD: begin
                    if (job_abort) begin
                        abort_pend_reg <= 1'b1;
                    end
                    if (col_accept) begin
                        if (abort_pend_reg || job_abort) begin
                            state_reg <= S_IDLE;
                        end else begin
                            cols_done_reg <= cols_done_reg + (K_W+1)'(1);
                            remaining_reg <= remaining_reg - (K_W+1)'(1);
                            if (remaining_reg == (K_W+1)'(1)) begin
                                job_done_reg <= 1'b1;
                                state_reg    <= S_IDLE;
                            end else begin
                                cur_k_reg <= cur_k_reg + K_W'(1);
                                state_reg <= S_ISSUE;
                            end
                        end
                    end else if (!col_valid) begin
                        wd_reg <= wd_inc;
                        if (wd_inc == TO_LAST) begin
                            job_err_reg <= 1'b1;
                            state_reg   <= S_IDLE;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wtile_load_sched.sv
// Directed bench for wtile_load_sched: a small loader model answers start_k after a
// programmable latency while each task drives one scenario and checks outputs inline.
module tb_wtile_load_sched;

    localparam int KMAX = 1024;
    localparam int K_W  = 10;

    logic           clk;
    logic           rst;
    logic           job_start;
    logic [K_W-1:0] job_k_base;
    logic [K_W:0]   job_k_len;
    logic           job_abort;
    logic           job_ready;
    logic           job_done;
    logic           job_err;
    logic [K_W:0]   cols_done;
    logic           start_k;
    logic [K_W-1:0] k_idx;
    logic           col_valid;
    logic           col_accept;
    logic           cons_valid;
    logic           cons_ready;
    logic           cpu_req;
    logic           cpu_gnt;

    int tests_run;
    int tests_failed;

    // loader model controls and monitor counters
    bit loader_en;
    int loader_lat;
    int n_start, n_accept, n_done, n_err, n_gnt, n_gnt_busy, gnt_bad, max_run;
    int start_log [0:127];

    wtile_load_sched #(
        .KMAX(KMAX), .K_W(K_W), .CPU_BURST_MAX(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .job_start(job_start), .job_k_base(job_k_base), .job_k_len(job_k_len),
        .job_abort(job_abort), .job_ready(job_ready), .job_done(job_done),
        .job_err(job_err), .cols_done(cols_done), .start_k(start_k), .k_idx(k_idx),
        .col_valid(col_valid), .col_accept(col_accept), .cons_valid(cons_valid),
        .cons_ready(cons_ready), .cpu_req(cpu_req), .cpu_gnt(cpu_gnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Loader: raises col_valid loader_lat cycles after start_k, drops it after accept.
    initial begin
        int  ld_cnt;
        bit  ld_s, ld_a;
        col_valid = 1'b0;
        ld_cnt = 0;
        forever begin
            @(negedge clk);
            ld_s = start_k;
            ld_a = col_accept;
            @(posedge clk);
            #1;
            if (rst) begin
                col_valid = 1'b0;
                ld_cnt = 0;
            end else begin
                if (ld_a) col_valid = 1'b0;
                if (ld_s && loader_en) begin
                    if (loader_lat <= 1) col_valid = 1'b1;
                    else ld_cnt = loader_lat - 1;
                end else if (ld_cnt > 0) begin
                    ld_cnt--;
                    if (ld_cnt == 0) col_valid = 1'b1;
                end
            end
        end
    end

    // Monitor: tallies pulses and CPU grants observed on the outputs.
    initial begin
        bit in_win;
        int run;
        in_win = 0; run = 0;
        n_start = 0; n_accept = 0; n_done = 0; n_err = 0;
        n_gnt = 0; n_gnt_busy = 0; gnt_bad = 0; max_run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_win = 0;
                run = 0;
            end else begin
                if (start_k) begin
                    start_log[n_start % 128] = int'(k_idx);
                    n_start++;
                    in_win = 1;
                end
                if (in_win && cpu_gnt) gnt_bad++;
                if (col_accept) begin
                    n_accept++;
                    in_win = 0;
                end
                if (job_done) n_done++;
                if (job_err) n_err++;
                if (cpu_gnt) n_gnt++;
                if (cpu_gnt && !job_ready) begin
                    n_gnt_busy++;
                    run++;
                    if (run > max_run) max_run = run;
                end else begin
                    run = 0;
                end
            end
        end
    end

    task automatic start_job(input int base, input int len);
        @(posedge clk);
        #1;
        job_start  = 1'b1;
        job_k_base = K_W'(base);
        job_k_len  = (K_W+1)'(len);
        @(posedge clk);
        #1;
        job_start = 1'b0;
    endtask

    task automatic wait_end(input int d0, input int e0, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (n_done != d0 || n_err != e0) begin
                timed_out = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset;
        cpu_req = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({job_ready, job_done, job_err, start_k, col_accept, cons_valid, cpu_gnt} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {job_ready, job_done, job_err, start_k, col_accept, cons_valid, cpu_gnt});
        end
        tests_run++;
        if (cols_done !== '0 || k_idx !== '0) begin
            tests_failed++;
            $display("FAIL reset_counts: cols_done=%0d k_idx=%0d want 0 0", cols_done, k_idx);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (job_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b want 1", job_ready);
        end
    endtask

    task automatic test_single_job;
        int s0, a0, d0, e0, g0;
        bit to;
        s0 = n_start; a0 = n_accept; d0 = n_done; e0 = n_err; g0 = n_gnt;
        loader_lat = 2; cons_ready = 1'b1;
        start_job(5, 3);
        wait_end(d0, e0, to);
        repeat (3) @(negedge clk);
        tests_run++;
        if (to || n_done - d0 != 1 || n_err != e0) begin
            tests_failed++;
            $display("FAIL single_done: done=%0d err=%0d timeout=%0b want 1 0 0", n_done - d0, n_err - e0, to);
        end
        tests_run++;
        if (n_start - s0 != 3 || start_log[s0 % 128] != 5 || start_log[(s0 + 1) % 128] != 6
            || start_log[(s0 + 2) % 128] != 7) begin
            tests_failed++;
            $display("FAIL single_k_idx: starts=%0d k=%0d,%0d,%0d want 3 k=5,6,7", n_start - s0,
                     start_log[s0 % 128], start_log[(s0 + 1) % 128], start_log[(s0 + 2) % 128]);
        end
        tests_run++;
        if (n_accept - a0 != 3 || cols_done !== 11'd3 || n_gnt != g0) begin
            tests_failed++;
            $display("FAIL single_accept: accepts=%0d cols_done=%0d gnts=%0d want 3 3 0",
                     n_accept - a0, cols_done, n_gnt - g0);
        end
    endtask

    task automatic test_zero_len;
        int s0;
        s0 = n_start;
        start_job(9, 0);
        @(negedge clk);
        tests_run++;
        if (job_done !== 1'b1 || job_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_len_done: done=%b err=%b want 1 0", job_done, job_err);
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (n_start != s0 || cols_done !== '0 || job_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_len_idle: starts=%0d cols_done=%0d ready=%b want 0 0 1",
                     n_start - s0, cols_done, job_ready);
        end
    endtask

    task automatic test_range;
        int s0, a0, d0, e0;
        bit to;
        s0 = n_start; d0 = n_done;
        start_job(1020, 8);
        @(negedge clk);
        tests_run++;
        if (job_err !== 1'b1 || job_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL range_err: err=%b ready=%b want 1 1", job_err, job_ready);
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (n_start != s0 || n_done != d0) begin
            tests_failed++;
            $display("FAIL range_no_start: starts=%0d done=%0d want 0 0", n_start - s0, n_done - d0);
        end
        s0 = n_start; a0 = n_accept; d0 = n_done; e0 = n_err;
        start_job(1016, 8);
        wait_end(d0, e0, to);
        tests_run++;
        if (to || n_done - d0 != 1 || n_err != e0 || n_accept - a0 != 8 || cols_done !== 11'd8) begin
            tests_failed++;
            $display("FAIL range_edge_job: done=%0d err=%0d accepts=%0d cols_done=%0d want 1 0 8 8",
                     n_done - d0, n_err - e0, n_accept - a0, cols_done);
        end
        tests_run++;
        if (n_start - s0 != 8 || start_log[(s0 + 7) % 128] != 1023) begin
            tests_failed++;
            $display("FAIL range_last_k: starts=%0d last_k=%0d want 8 1023",
                     n_start - s0, start_log[(s0 + 7) % 128]);
        end
    endtask

    task automatic test_cpu_burst;
        int a0, d0, e0, gb0, bad0;
        bit to;
        a0 = n_accept; d0 = n_done; e0 = n_err; gb0 = n_gnt_busy; bad0 = gnt_bad;
        loader_lat = 2; cons_ready = 1'b1;
        @(posedge clk);
        #1;
        cpu_req = 1'b1;
        job_start = 1'b1; job_k_base = 10'd0; job_k_len = 11'd3;
        @(negedge clk);
        tests_run++;
        if (cpu_gnt !== 1'b1) begin
            tests_failed++;
            $display("FAIL cpu_gnt_at_start: got %b want 1", cpu_gnt);
        end
        @(posedge clk);
        #1;
        job_start = 1'b0;
        wait_end(d0, e0, to);
        tests_run++;
        if (to || n_done - d0 != 1 || n_accept - a0 != 3) begin
            tests_failed++;
            $display("FAIL cpu_job_done: done=%0d accepts=%0d timeout=%0b want 1 3 0",
                     n_done - d0, n_accept - a0, to);
        end
        tests_run++;
        if (n_gnt_busy - gb0 != 12 || max_run != 4 || gnt_bad != bad0) begin
            tests_failed++;
            $display("FAIL cpu_burst: busy_gnts=%0d max_run=%0d gnt_in_load=%0d want 12 4 0",
                     n_gnt_busy - gb0, max_run, gnt_bad - bad0);
        end
        cpu_req = 1'b0;
    endtask

    task automatic test_stall;
        int d0, e0, bad;
        bit to, seen;
        d0 = n_done; e0 = n_err; bad = 0; seen = 0;
        loader_lat = 2; cons_ready = 1'b0;
        start_job(100, 1);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (col_valid) seen = 1;
        end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (col_accept !== 1'b0 || cons_valid !== 1'b1 || k_idx !== 10'd100) bad++;
        end
        tests_run++;
        if (!seen || bad != 0 || n_err != e0) begin
            tests_failed++;
            $display("FAIL stall_hold: valid_seen=%0b bad_cycles=%0d errs=%0d want 1 0 0", seen, bad, n_err - e0);
        end
        @(posedge clk);
        #1;
        cons_ready = 1'b1;
        wait_end(d0, e0, to);
        tests_run++;
        if (to || n_done - d0 != 1 || cols_done !== 11'd1) begin
            tests_failed++;
            $display("FAIL stall_release: done=%0d cols_done=%0d timeout=%0b want 1 1 0",
                     n_done - d0, cols_done, to);
        end
    endtask

    task automatic test_timeout;
        int d0, cnt;
        bit found, hit;
        d0 = n_done; found = 0; hit = 0; cnt = 0;
        loader_en = 1'b0;
        start_job(0, 1);
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (start_k) found = 1;
        end
        for (int i = 0; i < 40 && found && !hit; i++) begin
            @(negedge clk);
            cnt++;
            if (job_err) hit = 1;
        end
        tests_run++;
        if (!hit || cnt != 16) begin
            tests_failed++;
            $display("FAIL timeout_err: err_seen=%0b cycles_after_start_k=%0d want 1 16", hit, cnt);
        end
        @(negedge clk);
        tests_run++;
        if (job_ready !== 1'b1 || n_done != d0) begin
            tests_failed++;
            $display("FAIL timeout_idle: ready=%b done=%0d want 1 0", job_ready, n_done - d0);
        end
        loader_en = 1'b1;
    endtask

    task automatic test_abort;
        int s0, d0;
        bit found, seen;
        s0 = n_start; d0 = n_done; found = 0; seen = 0;
        loader_lat = 4; cons_ready = 1'b0;
        start_job(10, 2);
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (start_k) found = 1;
        end
        @(posedge clk);
        #1;
        job_abort = 1'b1;
        @(posedge clk);
        #1;
        job_abort = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (col_valid) seen = 1;
        end
        tests_run++;
        if (!seen || col_accept !== 1'b1 || cons_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_drain: valid_seen=%0b accept=%b cons_valid=%b want 1 1 0",
                     seen, col_accept, cons_valid);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (job_ready !== 1'b1 || n_done != d0 || n_start - s0 != 1 || cols_done !== '0) begin
            tests_failed++;
            $display("FAIL abort_idle: ready=%b done=%0d starts=%0d cols_done=%0d want 1 0 1 0",
                     job_ready, n_done - d0, n_start - s0, cols_done);
        end
        loader_lat = 2;
    endtask

    task automatic test_async_reset;
        bit seen;
        seen = 0;
        loader_lat = 2; cons_ready = 1'b0;
        start_job(7, 2);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (col_valid) seen = 1;
        end
        #2;
        cons_ready = 1'b1;
        cpu_req = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if (!seen || {job_ready, job_done, job_err, start_k, col_accept, cons_valid, cpu_gnt} !== 7'b0
            || k_idx !== '0 || cols_done !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: valid_seen=%0b flags=%b k_idx=%0d cols_done=%0d want 1 0000000 0 0", seen,
                     {job_ready, job_done, job_err, start_k, col_accept, cons_valid, cpu_gnt}, k_idx, cols_done);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (job_ready !== 1'b1 || start_k !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset_release: ready=%b start_k=%b want 1 0", job_ready, start_k);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        job_start = 1'b0; job_k_base = '0; job_k_len = '0; job_abort = 1'b0;
        cons_ready = 1'b0; cpu_req = 1'b0;
        loader_en = 1'b1; loader_lat = 2;
        test_reset;
        test_single_job;
        test_zero_len;
        test_range;
        test_cpu_burst;
        test_stall;
        test_timeout;
        test_abort;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
